// File: rtl/core_hazard_unit.sv
// Pipeline hazard unit: per-stage producer tracking, forwarding selects, load-use stall, freeze and flush.
// Optional performance counters are built only when CORE_HAZARD_PERF_EN is defined.
module core_hazard_unit #(
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 2,
    localparam int SW      = $clog2(STAGES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic              i_id_src1_en,
    input  logic              i_id_src2_en,
    input  logic [4:0]        i_id_src1_addr,
    input  logic [4:0]        i_id_src2_addr,
    input  logic              i_id_dst_en,
    input  logic [4:0]        i_id_dst_addr,
    input  logic              i_id_is_load,
    input  logic              i_ex_redirect,
    input  logic              i_bus_conflict,
    input  logic              i_perf_clr,
    output logic              o_id_hold,
    output logic              o_flush_id,
    output logic              o_loaduse,
    output logic [STAGES-1:0] o_stage_hold,
    output logic [STAGES-1:0] o_stage_valid,
    output logic [SW-1:0]     o_fwd_sel1,
    output logic [SW-1:0]     o_fwd_sel2,
    output logic [31:0]       o_cnt_loaduse,
    output logic [31:0]       o_cnt_conflict,
    output logic [31:0]       o_cnt_flush
);

    // Index k-1 holds the record of stage k (stage 1 = EX).
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_dst_en;
    logic [STAGES-1:0] r_is_load;
    logic [4:0]        r_dst_addr [STAGES];
    logic              r_redir_pend;

    logic [STAGES-1:0] w_prod1;
    logic [STAGES-1:0] w_prod2;
    logic [SW-1:0]     w_sel1;
    logic [SW-1:0]     w_sel2;
    logic              w_lu1;
    logic              w_lu2;
    logic              w_redirect;
    logic              w_loaduse;
    logic              w_issue;

    always_comb begin
        w_prod1 = '0;
        w_prod2 = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_prod1[k] = r_valid[k] & r_dst_en[k] & (r_dst_addr[k] == i_id_src1_addr)
                         & (i_id_src1_addr != 5'd0);
            w_prod2[k] = r_valid[k] & r_dst_en[k] & (r_dst_addr[k] == i_id_src2_addr)
                         & (i_id_src2_addr != 5'd0);
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the result.
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        w_lu1  = 1'b0;
        w_lu2  = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (w_prod1[k]) begin
                w_sel1 = SW'(k + 1);
                w_lu1  = r_is_load[k] && (k < LOAD_LAT);
            end
            if (w_prod2[k]) begin
                w_sel2 = SW'(k + 1);
                w_lu2  = r_is_load[k] && (k < LOAD_LAT);
            end
        end
        if (!i_id_src1_en) begin
            w_sel1 = '0;
            w_lu1  = 1'b0;
        end
        if (!i_id_src2_en) begin
            w_sel2 = '0;
            w_lu2  = 1'b0;
        end
    end

    // A redirect that arrived while frozen is remembered until the freeze lifts.
    assign w_redirect = i_ex_redirect | r_redir_pend;
    assign w_loaduse  = i_id_valid & (w_lu1 | w_lu2);
    assign w_issue    = i_id_valid & ~w_loaduse & ~w_redirect;

    assign o_loaduse     = w_loaduse;
    assign o_flush_id    = w_redirect & ~i_bus_conflict;
    assign o_id_hold     = i_bus_conflict | (w_loaduse & ~w_redirect);
    assign o_stage_hold  = {1'b0, {(STAGES-1){i_bus_conflict}}};
    assign o_stage_valid = r_valid;
    assign o_fwd_sel1    = w_sel1;
    assign o_fwd_sel2    = w_sel2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid      <= '0;
            r_dst_en     <= '0;
            r_is_load    <= '0;
            r_redir_pend <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_dst_addr[k] <= '0;
            end
        end else if (i_bus_conflict) begin
            // Frozen: only the last stage drains, so it receives a bubble.
            r_valid[STAGES-1]    <= 1'b0;
            r_dst_en[STAGES-1]   <= 1'b0;
            r_is_load[STAGES-1]  <= 1'b0;
            r_dst_addr[STAGES-1] <= '0;
            r_redir_pend         <= r_redir_pend | i_ex_redirect;
        end else begin
            r_valid      <= {r_valid[STAGES-2:0], w_issue};
            r_dst_en     <= {r_dst_en[STAGES-2:0], i_id_dst_en};
            r_is_load    <= {r_is_load[STAGES-2:0], i_id_is_load};
            r_redir_pend <= 1'b0;
            for (int k = STAGES - 1; k > 0; k--) begin
                r_dst_addr[k] <= r_dst_addr[k-1];
            end
            r_dst_addr[0] <= i_id_dst_addr;
        end
    end

`ifdef CORE_HAZARD_PERF_EN
    logic [31:0] r_cnt_loaduse;
    logic [31:0] r_cnt_conflict;
    logic [31:0] r_cnt_flush;
    logic        w_inc_loaduse;

    assign w_inc_loaduse = w_loaduse & ~i_bus_conflict & ~w_redirect;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_loaduse  <= '0;
            r_cnt_conflict <= '0;
            r_cnt_flush    <= '0;
        end else if (i_perf_clr) begin
            r_cnt_loaduse  <= '0;
            r_cnt_conflict <= '0;
            r_cnt_flush    <= '0;
        end else begin
            if (w_inc_loaduse && (r_cnt_loaduse != 32'hFFFF_FFFF)) begin
                r_cnt_loaduse <= r_cnt_loaduse + 32'd1;
            end
            if (i_bus_conflict && (r_cnt_conflict != 32'hFFFF_FFFF)) begin
                r_cnt_conflict <= r_cnt_conflict + 32'd1;
            end
            if (o_flush_id && (r_cnt_flush != 32'hFFFF_FFFF)) begin
                r_cnt_flush <= r_cnt_flush + 32'd1;
            end
        end
    end

    assign o_cnt_loaduse  = r_cnt_loaduse;
    assign o_cnt_conflict = r_cnt_conflict;
    assign o_cnt_flush    = r_cnt_flush;
`else
    logic w_unused_perf_clr;

    assign w_unused_perf_clr = i_perf_clr;
    assign o_cnt_loaduse     = '0;
    assign o_cnt_conflict    = '0;
    assign o_cnt_flush       = '0;
`endif

endmodule

// File: tb/tb_core_hazard_unit.sv
// Directed self-checking bench for core_hazard_unit (STAGES=3, LOAD_LAT=2).
// Counter expectations follow CORE_HAZARD_PERF_EN as seen by this compile.
module tb_core_hazard_unit;
    localparam int STAGES   = 3;
    localparam int LOAD_LAT = 2;
    localparam int SW       = 2;
`ifdef CORE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              id_valid;
    logic              src1_en;
    logic              src2_en;
    logic [4:0]        src1_addr;
    logic [4:0]        src2_addr;
    logic              dst_en;
    logic [4:0]        dst_addr;
    logic              is_load;
    logic              ex_redirect;
    logic              bus_conflict;
    logic              perf_clr;
    logic              id_hold;
    logic              flush_id;
    logic              loaduse;
    logic [STAGES-1:0] stage_hold;
    logic [STAGES-1:0] stage_valid;
    logic [SW-1:0]     fwd_sel1;
    logic [SW-1:0]     fwd_sel2;
    logic [31:0]       cnt_loaduse;
    logic [31:0]       cnt_conflict;
    logic [31:0]       cnt_flush;

    int n_checks = 0;
    int n_errors = 0;

    core_hazard_unit #(.STAGES(STAGES), .LOAD_LAT(LOAD_LAT)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_valid     (id_valid),
        .i_id_src1_en   (src1_en),
        .i_id_src2_en   (src2_en),
        .i_id_src1_addr (src1_addr),
        .i_id_src2_addr (src2_addr),
        .i_id_dst_en    (dst_en),
        .i_id_dst_addr  (dst_addr),
        .i_id_is_load   (is_load),
        .i_ex_redirect  (ex_redirect),
        .i_bus_conflict (bus_conflict),
        .i_perf_clr     (perf_clr),
        .o_id_hold      (id_hold),
        .o_flush_id     (flush_id),
        .o_loaduse      (loaduse),
        .o_stage_hold   (stage_hold),
        .o_stage_valid  (stage_valid),
        .o_fwd_sel1     (fwd_sel1),
        .o_fwd_sel2     (fwd_sel2),
        .o_cnt_loaduse  (cnt_loaduse),
        .o_cnt_conflict (cnt_conflict),
        .o_cnt_flush    (cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_id(input logic v, input logic s1e, input logic [4:0] s1,
                            input logic s2e, input logic [4:0] s2,
                            input logic de, input logic [4:0] d, input logic ld);
        id_valid  = v;
        src1_en   = s1e;
        src1_addr = s1;
        src2_en   = s2e;
        src2_addr = s2;
        dst_en    = de;
        dst_addr  = d;
        is_load   = ld;
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        ex_redirect  = 1'b0;
        bus_conflict = 1'b0;
        perf_clr     = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        ex_redirect  = 1'b0;
        bus_conflict = 1'b0;
        perf_clr     = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_stage_valid", 32'(stage_valid), 32'd0);
        check("rst_id_hold", 32'(id_hold), 32'd0);
        check("rst_flush", 32'(flush_id), 32'd0);
        check("rst_loaduse", 32'(loaduse), 32'd0);
        check("rst_fwd1", 32'(fwd_sel1), 32'd0);
        check("rst_fwd2", 32'(fwd_sel2), 32'd0);
        check("rst_stage_hold", 32'(stage_hold), 32'd0);
        check("rst_cnt_lu", cnt_loaduse, 32'd0);

        // Load x5 then a consumer of x5: two stall cycles, then forward from WB.
        drive_id(1, 0, 0, 0, 0, 1, 5, 1);
        tick();
        drive_id(1, 1, 5, 0, 0, 1, 6, 0);
        check("lu1_loaduse", 32'(loaduse), 32'd1);
        check("lu1_hold", 32'(id_hold), 32'd1);
        check("lu1_fwd1", 32'(fwd_sel1), 32'd1);
        check("lu1_valid", 32'(stage_valid), 32'b001);
        tick();
        check("lu2_loaduse", 32'(loaduse), 32'd1);
        check("lu2_hold", 32'(id_hold), 32'd1);
        check("lu2_fwd1", 32'(fwd_sel1), 32'd2);
        check("lu2_valid", 32'(stage_valid), 32'b010);
        tick();
        check("lu3_loaduse", 32'(loaduse), 32'd0);
        check("lu3_hold", 32'(id_hold), 32'd0);
        check("lu3_fwd1", 32'(fwd_sel1), 32'd3);
        check("lu3_valid", 32'(stage_valid), 32'b100);
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        check("lu4_valid", 32'(stage_valid), 32'b001);

        // Two ALU writers of x7: youngest wins, no stall.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 7, 0);
        tick();
        tick();
        drive_id(1, 1, 7, 1, 7, 0, 0, 0);
        check("alu_fwd1", 32'(fwd_sel1), 32'd1);
        check("alu_fwd2", 32'(fwd_sel2), 32'd1);
        check("alu_loaduse", 32'(loaduse), 32'd0);
        check("alu_hold", 32'(id_hold), 32'd0);
        drive_id(1, 1, 7, 0, 7, 0, 0, 0);
        check("alu_src2_off", 32'(fwd_sel2), 32'd0);

        // Younger ALU shadows an older load of the same register.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 9, 1);
        tick();
        drive_id(1, 0, 0, 0, 0, 1, 9, 0);
        tick();
        drive_id(1, 0, 0, 1, 9, 0, 0, 0);
        check("shadow_fwd2", 32'(fwd_sel2), 32'd1);
        check("shadow_loaduse", 32'(loaduse), 32'd0);

        // x0 is never produced, even by a load.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 0, 1);
        tick();
        drive_id(1, 1, 0, 1, 0, 0, 0, 0);
        check("x0_valid", 32'(stage_valid), 32'b001);
        check("x0_fwd1", 32'(fwd_sel1), 32'd0);
        check("x0_fwd2", 32'(fwd_sel2), 32'd0);
        check("x0_loaduse", 32'(loaduse), 32'd0);

        // Freeze with full pipe: WB drains, stages 1-2 hold.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        drive_id(1, 0, 0, 0, 0, 1, 2, 0);
        tick();
        drive_id(1, 0, 0, 0, 0, 1, 3, 0);
        tick();
        check("frz_full", 32'(stage_valid), 32'b111);
        bus_conflict = 1'b1;
        drive_id(1, 1, 1, 1, 2, 1, 4, 0);
        check("frz_stage_hold", 32'(stage_hold), 32'b011);
        check("frz_id_hold", 32'(id_hold), 32'd1);
        check("frz_fwd1_pre", 32'(fwd_sel1), 32'd3);
        check("frz_fwd2_pre", 32'(fwd_sel2), 32'd2);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("frz_c%0d_valid", c), 32'(stage_valid), 32'b011);
            check($sformatf("frz_c%0d_fwd1", c), 32'(fwd_sel1), 32'd0);
            check($sformatf("frz_c%0d_fwd2", c), 32'(fwd_sel2), 32'd2);
            if (c == 3) begin
                bus_conflict = 1'b0;
                #1;
            end
        end
        check("frz_off_stage_hold", 32'(stage_hold), 32'd0);
        check("frz_off_id_hold", 32'(id_hold), 32'd0);
        check("frz_cnt_conflict", cnt_conflict, PERF ? 32'd3 : 32'd0);
        tick();
        drive_id(1, 1, 4, 1, 2, 0, 0, 0);
        check("frz_resume_valid", 32'(stage_valid), 32'b111);
        check("frz_resume_fwd1", 32'(fwd_sel1), 32'd1);
        check("frz_resume_fwd2", 32'(fwd_sel2), 32'd3);

        // Redirect beats load-use: no hold, ID squashed, stage 1 gets a bubble.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 5, 1);
        tick();
        ex_redirect = 1'b1;
        drive_id(1, 1, 5, 0, 0, 0, 0, 0);
        check("rd_loaduse", 32'(loaduse), 32'd1);
        check("rd_hold", 32'(id_hold), 32'd0);
        check("rd_flush", 32'(flush_id), 32'd1);
        tick();
        ex_redirect = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        check("rd_valid", 32'(stage_valid), 32'b010);
        check("rd_cnt_flush", cnt_flush, PERF ? 32'd1 : 32'd0);
        check("rd_cnt_lu", cnt_loaduse, 32'd0);

        // Redirect under freeze: flush only once the freeze lifts.
        do_reset();
        ex_redirect  = 1'b1;
        bus_conflict = 1'b1;
        #1;
        check("rf_c1_flush", 32'(flush_id), 32'd0);
        check("rf_c1_hold", 32'(id_hold), 32'd1);
        tick();
        check("rf_c2_flush", 32'(flush_id), 32'd0);
        tick();
        bus_conflict = 1'b0;
        #1;
        check("rf_c3_flush", 32'(flush_id), 32'd1);
        check("rf_c3_hold", 32'(id_hold), 32'd0);
        tick();
        ex_redirect = 1'b0;
        #1;
        check("rf_c4_flush", 32'(flush_id), 32'd0);
        check("rf_cnt_flush", cnt_flush, PERF ? 32'd1 : 32'd0);
        check("rf_cnt_conflict", cnt_conflict, PERF ? 32'd2 : 32'd0);

        // Chained loads give five counted load-use cycles, then clear with load-use active.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 5, 1);
        tick();
        drive_id(1, 1, 5, 0, 0, 1, 6, 1);
        tick();
        tick();
        tick();
        drive_id(1, 1, 6, 0, 0, 1, 7, 1);
        tick();
        tick();
        tick();
        drive_id(1, 1, 7, 0, 0, 0, 0, 0);
        tick();
        perf_clr = 1'b1;
        #1;
        check("pc_loaduse", 32'(loaduse), 32'd1);
        check("pc_cnt_before", cnt_loaduse, PERF ? 32'd5 : 32'd0);
        tick();
        perf_clr = 1'b0;
        #1;
        check("pc_cnt_after", cnt_loaduse, 32'd0);
        check("pc_fwd1", 32'(fwd_sel1), 32'd3);
        check("pc_loaduse_done", 32'(loaduse), 32'd0);

        // Async reset mid-freeze with a pending redirect discards everything.
        do_reset();
        drive_id(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        tick();
        tick();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus_conflict = 1'b1;
        ex_redirect  = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(stage_valid), 32'd0);
        bus_conflict = 1'b0;
        ex_redirect  = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("ar_flush", 32'(flush_id), 32'd0);
        check("ar_hold", 32'(id_hold), 32'd0);
        tick();
        check("ar_flush_next", 32'(flush_id), 32'd0);
        check("ar_valid_next", 32'(stage_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_hazard_unit.md
CORE_HAZARD_UNIT -- requirements
Module: core_hazard_unit

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of tracked post-ID stages (stage 1 = EX, stage STAGES = WB), legal 2..7.
REQ-002 SHALL have parameter LOAD_LAT, default 2, load result forwardable only from stage k > LOAD_LAT, legal 1..STAGES-1.
REQ-003 SHALL derive SW = $clog2(STAGES+1) as the width of the forward selects.
REQ-004 Ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state on rising edge.
  rst  in  1  asynchronous active-high reset.
  id_valid  in  1  ID holds a real instruction.
  id_src1_en / id_src2_en  in  1  ID reads rs1 / rs2.
  id_src1_addr / id_src2_addr  in  5  rs1 / rs2 index.
  id_dst_en  in  1  ID instruction writes rd.
  id_dst_addr  in  5  rd index.
  id_is_load  in  1  ID instruction is a load.
  ex_redirect  in  1  stage-1 branch/jalr taken.
  bus_conflict  in  1  data bus busy; freeze request.
  perf_clr  in  1  synchronous clear of counters.
  id_hold  out  1  ID and fetch hold this cycle.
  flush_id  out  1  squash ID instruction.
  loaduse  out  1  load-use hazard detected.
  stage_hold  out  STAGES  per-stage register enable inverse.
  stage_valid  out  STAGES  per-stage occupancy.
  fwd_sel1 / fwd_sel2  out  SW  0 = regfile, k = forward from stage k.
  cnt_loaduse / cnt_conflict / cnt_flush  out  32  performance counters.

Function
REQ-005 SHALL keep per tracked stage k a record {valid, dst_en, dst_addr, is_load}.
REQ-006 SHALL treat a record as a producer of register r iff valid & dst_en & dst_addr==r & r!=0.
REQ-007 fwd_selN SHALL be the smallest k whose record produces srcN (youngest wins), else 0; 0 when id_srcN_en=0.
REQ-008 loaduse SHALL assert iff id_valid and the youngest producer of an enabled source is a load in stage k <= LOAD_LAT.
REQ-009 flush_id SHALL equal ex_redirect & ~bus_conflict.
REQ-010 id_hold SHALL equal bus_conflict | (loaduse & ~ex_redirect).
REQ-011 stage_hold[k-1] SHALL equal bus_conflict for k<STAGES; stage_hold[STAGES-1] SHALL be 0.
REQ-012 Priority SHALL be bus_conflict > ex_redirect > loaduse.
REQ-013 On bus_conflict: stages 1..STAGES-1 hold contents; stage STAGES loads an invalid record.
REQ-014 Otherwise: stage k+1 loads stage k; stage 1 loads the ID record with valid = id_valid & ~loaduse & ~ex_redirect.
REQ-015 A redirect held by bus_conflict SHALL take effect on the first cycle bus_conflict is low (flush exactly once).
REQ-016 stage_valid SHALL reflect registered valid bits; all outputs except counters are combinational from state and inputs, zero latency.

Reset
REQ-017 rst SHALL asynchronously clear all valid bits, dst fields, is_load bits and counters to 0.
REQ-018 After rst release with id_valid=0: id_hold=0, flush_id=0, loaduse=0, fwd_sel*=0, stage_valid=0.
REQ-019 rst asserted mid-stall SHALL discard all in-flight records; no pending redirect survives.

Configuration
REQ-020 Macro CORE_HAZARD_PERF_EN: when defined, counters are included.
REQ-021 With the macro, cnt_loaduse increments per cycle loaduse & ~bus_conflict & ~ex_redirect, cnt_conflict per cycle bus_conflict, cnt_flush per cycle flush_id; saturate at 0xFFFFFFFF; perf_clr zeroes them (clear wins over increment).
REQ-022 Without the macro, the three counter outputs SHALL be constant 0 and no counter flops exist.

Verification
REQ-023 STAGES=3, LOAD_LAT=2: load x5 in stage 1, ID reads x5 -> loaduse=1, id_hold=1 two cycles, then fwd_sel1=3.
REQ-024 ALU writes x7 in stage 1 and stage 2, ID reads x7 -> fwd_sel1=1 (youngest), no hold.
REQ-025 ID reads x0 with stage-1 producer dst_addr=0 -> fwd_sel1=0, loaduse=0.
REQ-026 bus_conflict high 3 cycles with stages full -> stage_hold=3'b011, stage 3 invalid after cycle 1, stages 1-2 unchanged.
REQ-027 ex_redirect and bus_conflict together for 2 cycles, then conflict drops -> flush_id=0,0 then 1 once; cnt_flush=1.
REQ-028 PERF_EN, 5 loaduse cycles then perf_clr with loaduse active -> cnt_loaduse=5, then 0.
